pc_stack_unit: RTL

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/musa_pkg.sv | 16 +
 rtl/ret_stack.sv | 67 ++++++
 rtl/pc_stack_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/musa_pkg.sv
// Shared definitions for the PC / return-stack unit.
// Holds the branch-select encoding used by the control unit and the default
// PC/address width.
package musa_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 16;

  // Branch select from the control unit; BR_RSVD behaves as sequential.
  typedef enum logic [1:0] {
    BR_SEQ     = 2'b00,
    BR_CALLRET = 2'b01,
    BR_COND    = 2'b10,
    BR_RSVD    = 2'b11
  } branch_e;

endpackage : musa_pkg

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses with occupancy pointer.
// Ports:
//   clk, rst            - clock, synchronous active-high reset (clears pointer only)
//   push_i / pop_i      - push wdata_i / drop top entry (ignored when full / empty)
//   wdata_i             - address to push
//   top_o               - top entry, 0 while empty (combinational from registered state)
//   full_o / empty_o    - occupancy == DEPTH / occupancy == 0
module ret_stack #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (ptr_q == PTR_W'(DEPTH));
  assign empty_o = (ptr_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the low bits of the pointer address the RAM.
  assign wr_idx  = IDX_W'(ptr_q);
  assign top_idx = IDX_W'(ptr_q - PTR_W'(1));
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  // Pointer next-state; push and pop are never both presented by the owner.
  always_comb begin
    ptr_d = ptr_q;
    if (do_push) begin
      ptr_d = ptr_q + PTR_W'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is intentionally not reset; the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= wdata_i;
    end
  end

endmodule : ret_stack

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with call/return stack.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (priority over en)
//   en           - advance strobe; state holds while low
//   branch       - 00 seq, 01 call/ret/jump, 10 conditional, 11 treated as seq
//   push, pop    - call / return qualifiers for branch=01
//   flag         - condition for branch=10
//   target       - jump/branch destination
//   pc           - registered current PC
//   ret_addr     - stack top (0 when empty)
//   stack_full, stack_empty - stack occupancy status
//   ovf_err, unf_err, seq_err - sticky error flags
// Build option: define PC_STACK_ERR_EN to implement the sticky error flags;
// otherwise they are tied to 0 and no flag registers exist.
module pc_stack_unit
  import musa_pkg::*;
#(
  parameter int unsigned        ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned        DEPTH    = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        branch,
  input  logic              push,
  input  logic              pop,
  input  logic              flag,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              ovf_err,
  output logic              unf_err,
  output logic              seq_err
);

  branch_e           br;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              st_push;
  logic              st_pop;

  assign br     = branch_e'(branch);
  assign pc_inc = pc_q + ADDR_W'(1);
  assign pc     = pc_q;

  ret_stack #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (st_push),
    .pop_i   (st_pop),
    .wdata_i (pc_inc),
    .top_o   (ret_addr),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );

  // Next PC and stack requests; a call that hits a full stack still jumps.
  always_comb begin
    pc_d    = pc_q;
    st_push = 1'b0;
    st_pop  = 1'b0;
    if (en) begin
      case (br)
        BR_COND: pc_d = flag ? target : pc_inc;
        BR_CALLRET: begin
          if (push && pop) begin
            pc_d = pc_inc;
          end else if (push) begin
            pc_d    = target;
            st_push = !stack_full;
          end else if (pop) begin
            if (stack_empty) begin
              pc_d = RESET_PC;
            end else begin
              pc_d   = ret_addr;
              st_pop = 1'b1;
            end
          end else begin
            pc_d = target;
          end
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_STACK_ERR_EN
  logic is_cr;
  logic ovf_set, unf_set, seq_set;
  logic ovf_q, unf_q, seq_q;

  assign is_cr   = en && (br == BR_CALLRET);
  assign ovf_set = is_cr && push && !pop && stack_full;
  assign unf_set = is_cr && pop && !push && stack_empty;
  assign seq_set = is_cr && push && pop;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      seq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
      seq_q <= seq_q | seq_set;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
  assign seq_err = seq_q;
`else
  assign ovf_err = 1'b0;
  assign unf_err = 1'b0;
  assign seq_err = 1'b0;
`endif

endmodule : pc_stack_unit
